// File: rtl/pdp_rdma_egress_if.sv
// pdp_rdma_egress_if: valid/ready stream carrying a W-bit payload.
//   pd    : payload, driven by master
//   valid : payload valid, driven by master
//   ready : sink ready, driven by slave
interface pdp_rdma_egress_if #(parameter int W = 64);
   logic [W-1:0] pd;
   logic         valid;
   logic         ready;
   modport master (output pd, valid, input ready);
   modport slave (input pd, valid, output ready);
endinterface

// File: rtl/pdp_rdma_egress.sv
// pdp_rdma_egress: tags off-fly RDMA read-return beats with cube position info for the PDP core.
//   nvdla_core_clk/nvdla_core_rst : clock, async active-high reset
//   reg2dp_*                      : layer enable and cube geometry (latched at layer start)
//   fifo_rd                       : 64-bit read-return stream in (slave)
//   pdp_rdma2dp                   : 76-bit {info, data} stream out (master), one register stage
//   rdma_layer_done               : one-cycle pulse after the final beat leaves
//   rdma_busy                     : high while a layer is in progress
module pdp_rdma_egress #(
   parameter int DW = 64,
   parameter int PW = DW + 12
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rst,
   input  logic              reg2dp_op_en,
   input  logic              reg2dp_flying_mode,
   input  logic [7:0]        reg2dp_split_num,
   input  logic [9:0]        reg2dp_width_first,
   input  logic [9:0]        reg2dp_width_mid,
   input  logic [9:0]        reg2dp_width_last,
   input  logic [12:0]       reg2dp_height,
   input  logic [7:0]        reg2dp_surf_num,
   pdp_rdma_egress_if.slave  fifo_rd,
   pdp_rdma_egress_if.master pdp_rdma2dp,
   output logic              rdma_layer_done,
   output logic              rdma_busy
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nx;
   logic op_en_d1, vld, start, load, out_hs;
   logic line_end, surf_end, cube_end, last_split, layer_end;
   logic [7:0] sh_split, sh_surf, s, p;
   logic [9:0] sh_wf, sh_wm, sh_wl, cur_w, w;
   logic [12:0] sh_height, h;
   logic [PW-1:0] pd;
   logic [11:0] info;
   assign start = reg2dp_op_en & ~op_en_d1 & reg2dp_flying_mode;
   assign out_hs = vld & pdp_rdma2dp.ready;
   assign fifo_rd.ready = (state == RUN) & (~vld | pdp_rdma2dp.ready);
   assign load = fifo_rd.valid & fifo_rd.ready;
   assign cur_w = (p == 8'd0) ? sh_wf : (p == sh_split) ? sh_wl : sh_wm;
   assign line_end = w == cur_w;
   assign surf_end = line_end & (h == sh_height);
   assign cube_end = surf_end & (s == sh_surf);
   assign last_split = p == sh_split;
   assign layer_end = cube_end & last_split;
   assign info = {cube_end, 3'b000, last_split, 1'b0, surf_end, line_end, w[3:0]};
   assign pdp_rdma2dp.pd = pd;
   assign pdp_rdma2dp.valid = vld;
   assign rdma_busy = state != IDLE;
   always_comb begin
      state_nx = (state == IDLE && start) ? RUN :
                 (state == RUN && load && layer_end) ? DRAIN :
                 (state == DRAIN && out_hs) ? IDLE : state;
   end
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst)
      if (nvdla_core_rst) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst)
      if (nvdla_core_rst) begin
         op_en_d1 <= 1'b0;
         rdma_layer_done <= 1'b0;
         vld <= 1'b0;
         pd <= '0;
         sh_split <= '0;
         sh_surf <= '0;
         sh_wf <= '0;
         sh_wm <= '0;
         sh_wl <= '0;
         sh_height <= '0;
         w <= '0;
         h <= '0;
         s <= '0;
         p <= '0;
      end else begin
         op_en_d1 <= reg2dp_op_en;
         rdma_layer_done <= (state == DRAIN) & out_hs;
         if (state == IDLE && start) begin
            sh_split <= reg2dp_split_num;
            sh_surf <= reg2dp_surf_num;
            sh_wf <= reg2dp_width_first;
            sh_wm <= reg2dp_width_mid;
            sh_wl <= reg2dp_width_last;
            sh_height <= reg2dp_height;
            w <= '0;
            h <= '0;
            s <= '0;
            p <= '0;
         end else if (load) begin
            // each counter clears on its own carry, the next one steps only on that carry
            w <= line_end ? '0 : w + 1'b1;
            if (line_end) h <= surf_end ? '0 : h + 1'b1;
            if (surf_end) s <= cube_end ? '0 : s + 1'b1;
            if (cube_end) p <= layer_end ? '0 : p + 1'b1;
         end
         if (load) begin
            pd <= {info, fifo_rd.pd};
            vld <= 1'b1;
         end else if (out_hs) vld <= 1'b0;
      end
endmodule

// File: tb/tb_pdp_rdma_egress.sv
// tb_pdp_rdma_egress: randomized layers checked against a nested-loop cube model.
module tb_pdp_rdma_egress;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic op_en = 1'b0;
   logic fly = 1'b1;
   logic [7:0] split = '0, surf = '0;
   logic [9:0] wf = '0, wm = '0, wl = '0;
   logic [12:0] ht = '0;
   logic done, busy;
   int n_chk = 0, n_fail = 0;
   logic [75:0] beats[$];
   pdp_rdma_egress_if #(.W(64)) fifo_rd();
   pdp_rdma_egress_if #(.W(76)) dp();
   pdp_rdma_egress dut (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg2dp_op_en(op_en),
      .reg2dp_flying_mode(fly), .reg2dp_split_num(split), .reg2dp_width_first(wf),
      .reg2dp_width_mid(wm), .reg2dp_width_last(wl), .reg2dp_height(ht),
      .reg2dp_surf_num(surf), .fifo_rd(fifo_rd), .pdp_rdma2dp(dp),
      .rdma_layer_done(done), .rdma_busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic build(input int sp, input int w0, input int w1, input int w2,
                        input int hh, input int ss, input bit fixed);
      int wd;
      logic le, se, ce, ls;
      logic [11:0] info;
      logic [63:0] data;
      beats.delete();
      for (int p = 0; p <= sp; p++) begin
         wd = (p == 0) ? w0 : (p == sp) ? w2 : w1;
         for (int s = 0; s <= ss; s++)
            for (int h = 0; h <= hh; h++)
               for (int w = 0; w <= wd; w++) begin
                  le = (w == wd);
                  se = le && (h == hh);
                  ce = se && (s == ss);
                  ls = (p == sp);
                  info = {ce, 3'b000, ls, 1'b0, se, le, 4'(w)};
                  data = fixed ? 64'h0123456789ABCDEF : {$urandom, $urandom};
                  beats.push_back({info, data});
               end
      end
   endtask
   task automatic run_layer(input int sp, input int w0, input int w1, input int w2,
                            input int hh, input int ss, input int mode,
                            input bit fixed, input int abort_at);
      int in_i, out_i, cyc, n, ends;
      bit done_exp, hold;
      logic [75:0] prev_pd;
      build(sp, w0, w1, w2, hh, ss, fixed);
      n = beats.size();
      @(posedge clk); #1;
      op_en = 1'b0;
      split = 8'(sp); wf = 10'(w0); wm = 10'(w1); wl = 10'(w2); ht = 13'(hh); surf = 8'(ss);
      @(posedge clk); #1;
      op_en = 1'b1;
      @(negedge clk);
      chk("busy_pre", 76'(busy), 76'd0);
      in_i = 0; out_i = 0; cyc = 0; ends = 0; done_exp = 1'b0; hold = 1'b0; prev_pd = '0;
      while (cyc < 4000) begin
         @(posedge clk); #1;
         if (abort_at > 0 && cyc == abort_at) begin
            rst = 1'b1;
            op_en = 1'b0;
            fifo_rd.valid = 1'b0;
            #1;
            chk("rst_valid", 76'(dp.valid), 76'd0);
            chk("rst_pd", dp.pd, 76'd0);
            chk("rst_prdy", 76'(fifo_rd.ready), 76'd0);
            chk("rst_busy", 76'(busy), 76'd0);
            chk("rst_done", 76'(done), 76'd0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (cyc == 3) begin
            split = 8'($urandom); wf = 10'($urandom); wm = 10'($urandom);
            wl = 10'($urandom); ht = 13'($urandom); surf = 8'($urandom);
         end
         if (mode == 3 && cyc == 5) op_en = 1'b0;
         if (mode == 3 && cyc == 7) op_en = 1'b1;
         fifo_rd.valid = (in_i < n) && ($urandom_range(3) != 0);
         fifo_rd.pd = (in_i < n) ? beats[in_i][63:0] : {$urandom, $urandom};
         dp.ready = (mode == 1) ? 1'($urandom_range(1)) : (mode == 2) ? !(cyc >= 8 && cyc < 13) : 1'b1;
         @(negedge clk);
         if (cyc == 0) chk("busy_run", 76'(busy), 76'd1);
         chk("done", 76'(done), 76'(done_exp));
         if (done_exp) begin
            chk("busy_idle", 76'(busy), 76'd0);
            chk("prdy_idle", 76'(fifo_rd.ready), 76'd0);
            break;
         end
         if (hold) begin
            chk("hold_pd", dp.pd, prev_pd);
            chk("hold_valid", 76'(dp.valid), 76'd1);
         end
         if (dp.valid && !dp.ready) chk("stall_prdy", 76'(fifo_rd.ready), 76'd0);
         if (in_i == n) chk("drain_prdy", 76'(fifo_rd.ready), 76'd0);
         hold = dp.valid && !dp.ready;
         prev_pd = dp.pd;
         if (dp.valid && dp.ready) begin
            if (out_i < n) chk("beat", dp.pd, beats[out_i]);
            else chk("extra_beat", 76'(dp.valid), 76'd0);
            if (fixed && out_i == 0) chk("atom_pd", dp.pd, 76'h8B0_0123456789ABCDEF);
            if (dp.pd[75] && dp.pd[71]) ends++;
            out_i++;
            done_exp = (out_i == n);
         end
         if (fifo_rd.valid && fifo_rd.ready) in_i++;
         cyc++;
      end
      chk("beats_out", 76'(out_i), 76'(n));
      chk("layer_end_cnt", 76'(ends), 76'd1);
      fifo_rd.valid = 1'b0;
   endtask
   initial begin
      fifo_rd.valid = 1'b0;
      fifo_rd.pd = '0;
      dp.ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 76'(dp.valid), 76'd0);
      chk("reset_pd", dp.pd, 76'd0);
      chk("reset_prdy", 76'(fifo_rd.ready), 76'd0);
      chk("reset_done", 76'(done), 76'd0);
      chk("reset_busy", 76'(busy), 76'd0);
      rst = 1'b0;
      run_layer(0, 0, 0, 0, 0, 0, 0, 1'b1, 0);
      run_layer(0, 3, 0, 0, 1, 1, 0, 1'b0, 0);
      run_layer(2, 1, 0, 2, 0, 0, 0, 1'b0, 0);
      run_layer(1, 4, 2, 3, 2, 1, 2, 1'b0, 0);
      run_layer(1, 3, 1, 2, 1, 1, 1, 1'b0, 0);
      run_layer(2, 2, 3, 1, 1, 0, 3, 1'b0, 0);
      fly = 1'b0;
      @(posedge clk); #1;
      op_en = 1'b0;
      @(posedge clk); #1;
      op_en = 1'b1;
      fifo_rd.valid = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("fly0_prdy", 76'(fifo_rd.ready), 76'd0);
         chk("fly0_busy", 76'(busy), 76'd0);
      end
      fifo_rd.valid = 1'b0;
      fly = 1'b1;
      run_layer(1, 5, 0, 5, 3, 2, 1, 1'b0, 20);
      run_layer(1, 2, 0, 3, 1, 1, 0, 1'b0, 0);
      repeat (6)
         run_layer(int'($urandom_range(3)), int'($urandom_range(5)), int'($urandom_range(5)),
                   int'($urandom_range(5)), int'($urandom_range(3)), int'($urandom_range(2)),
                   1, 1'b0, 0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
